mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the instruction fetch path and the control unit's load/store path.
- The load/store path uses the 2-bit `ls_en` request and the `ls_done` completion pulse.
- Arbitrates, issues exactly one memory access per grant, waits the fixed memory read latency, and returns data with a one-cycle acknowledge pulse.
- Sits between the control unit / fetch logic and the data/instruction memory.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory read latency in cycles, counted from the issue cycle; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_data is valid.
- if_data  out  DW  fetched word, registered; holds until the next fetch response.
- ls_en  in  2  00 none, 01 load, 10 store, 11 treated as none; held until ls_done.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_done  out  1  one-cycle completion pulse for a load or store.
- ls_rdata  out  DW  load data, registered; holds until the next load response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  read data; valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async, any state):
  - state = IDLE, wait counter = 0, last_grant = IF.
  - All outputs 0, including if_data and ls_rdata.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests. LS is pending when ls_en is 01 or 10; IF is pending when if_req = 1.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant (round-robin). After reset, LS therefore wins the first tie.
  - On a grant, latch addr, we, wdata and the grant owner; update last_grant; go to ISSUE.
  - Nothing pending: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we = 1 only for a store; mem_addr/mem_wdata come from the latched values.
  - Store: go to RESP. Load or fetch: go to WAIT with counter = MEM_LAT-1.
- WAIT (MEM_LAT cycles):
  - Counter decrements each cycle.
  - In the cycle where counter = 0, mem_rdata is captured into ls_rdata (LS load) or if_data (IF), and the state moves to RESP.
- RESP (1 cycle):
  - Pulse if_ack (IF owner) or ls_done (LS owner), driven from a register; then go to IDLE.
- Latency, with request seen in IDLE at cycle t:
  - Store: done at t+2.
  - Load or fetch: ack/done at t+2+MEM_LAT (t+3 for MEM_LAT = 1).
- Requester obligation: drop the request no later than the cycle after the ack/done pulse.
  - A request still high when IDLE is re-entered is treated as a new request.
  - The control unit satisfies this because it leaves its load/store wait state on the edge that ends ls_done.
- No new grant is taken while busy; a request arriving mid-access waits in IDLE arbitration.
- Between accesses mem_en = 0, and mem_addr/mem_wdata/mem_we are driven to 0.
- ls_en = 11 never produces a grant or a memory access.
- Reset asserted mid-access aborts the access: no ack/done pulse and no further mem_en. A store already strobed in ISSUE is not rolled back.
- if_data and ls_rdata change only when a response is captured.

Decomposition:
- Shared package:
  - State encoding (IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11).
  - ls_en codes LS_NONE = 2'b00, LS_LOAD = 2'b01, LS_STORE = 2'b10.
  - Grant-owner codes OWN_IF / OWN_LS.
- Optional sub-module `rr_arb2`: 2-way round-robin pick with last_grant state. Everything else stays in one module.

Test Plan:
1. Reset released, ls_en = 01, ls_addr = 0x0010, memory[0x10] = 0xBEEF, MEM_LAT = 1 -> exactly one mem_en/read cycle at t+1; ls_done pulse at t+3 with ls_rdata = 0xBEEF; if_ack stays 0.
2. ls_en = 10, ls_addr = 0x0020, ls_wdata = 0x1234 -> one mem_en cycle with mem_we = 1, mem_addr = 0x0020, mem_wdata = 0x1234; ls_done at t+2; a follow-up load from 0x0020 returns 0x1234.
3. if_req and ls_en = 01 both high from reset -> LS is served first, IF second; with both held continuously, grants alternate LS, IF, LS, IF.
4. MEM_LAT = 3, fetch from 0x0004 where memory = 0xA5A5 -> if_ack at t+5 with if_data = 0xA5A5; busy high from t+1 to t+5 inclusive.
5. ls_en = 11 for 10 cycles -> no mem_en, no ls_done, busy = 0 throughout.
6. Reset pulsed low during WAIT of a load -> all outputs 0 immediately; no ls_done; after release a new load completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [1:0] LS_NONE  = 2'b00;
  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Only the two defined codes count as a request; 2'b11 is ignored.
  function automatic logic ls_pending(input logic [1:0] en);
    return (en == LS_LOAD) || (en == LS_STORE);
  endfunction

  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and load/store, remembering the last winner.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_ls,
  input  logic update,
  output logic grant,
  output logic owner
);

  logic last_r;

  // Pick the requester that did not win last time when both are pending.
  always_comb begin
    grant = req_if | req_ls;
    if (req_if && req_ls) begin
      owner = (last_r == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (req_ls) begin
      owner = OWN_LS;
    end else begin
      owner = OWN_IF;
    end
  end

  // Last-grant memory; starts at IF so the load/store side wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= OWN_IF;
    end else if (update) begin
      last_r <= owner;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store,
// one access per grant, with a registered one-cycle acknowledge per completed access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_data,
  input  logic [1:0]    ls_en,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = cnt_width(MEM_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 32'sd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  owner_t        owner_r;
  owner_t        pick_s;
  logic          pick_raw_s;
  logic          we_r;
  logic          grant_s;
  logic          take_s;
  logic          cap_s;
  logic          store_s;
  logic          ls_pend_s;
  logic [AW-1:0] req_addr_s;
  logic [DW-1:0] req_wdata_s;

  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          if_ack_r;
  logic          ls_done_r;
  logic          busy_r;
  logic [DW-1:0] if_data_r;
  logic [DW-1:0] ls_rdata_r;

  assign ls_pend_s = ls_pending(ls_en);
  assign pick_s    = owner_t'(pick_raw_s);

  mem_port_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_if (if_req),
    .req_ls (ls_pend_s),
    .update (take_s),
    .grant  (grant_s),
    .owner  (pick_raw_s)
  );

  // Access attributes of whichever requester the arbiter currently picks.
  always_comb begin
    store_s     = 1'b0;
    req_addr_s  = {AW{1'b0}};
    req_wdata_s = {DW{1'b0}};
    if (pick_s == OWN_LS) begin
      store_s    = (ls_en == LS_STORE);
      req_addr_s = ls_addr;
      if (ls_en == LS_STORE) begin
        req_wdata_s = ls_wdata;
      end else begin
        req_wdata_s = {DW{1'b0}};
      end
    end else begin
      req_addr_s = if_addr;
    end
  end

  // Next-state logic; grants are only taken from IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    take_s  = 1'b0;
    cap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_ISSUE;
          take_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_r) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_RESP;
          cap_s   = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, wait counter and the owner/direction of the access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      owner_r <= OWN_IF;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (take_s) begin
        owner_r <= pick_s;
        we_r    <= store_s;
      end else begin
        owner_r <= owner_r;
        we_r    <= we_r;
      end
    end
  end

  // Registered outputs; the mem_* registers double as the grant-time address/data latch
  // and are only non-zero during the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      if_ack_r    <= 1'b0;
      ls_done_r   <= 1'b0;
      busy_r      <= 1'b0;
      if_data_r   <= {DW{1'b0}};
      ls_rdata_r  <= {DW{1'b0}};
    end else begin
      mem_en_r    <= take_s;
      mem_we_r    <= take_s & store_s;
      mem_addr_r  <= take_s ? req_addr_s : {AW{1'b0}};
      mem_wdata_r <= take_s ? req_wdata_s : {DW{1'b0}};
      if_ack_r    <= (state_s == ST_RESP) && (owner_r == OWN_IF);
      ls_done_r   <= (state_s == ST_RESP) && (owner_r == OWN_LS);
      busy_r      <= (state_s != ST_IDLE);
      if (cap_s && (owner_r == OWN_IF)) begin
        if_data_r <= mem_rdata;
      end else begin
        if_data_r <= if_data_r;
      end
      if (cap_s && (owner_r == OWN_LS)) begin
        ls_rdata_r <= mem_rdata;
      end else begin
        ls_rdata_r <= ls_rdata_r;
      end
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_ack    = if_ack_r;
  assign ls_done   = ls_done_r;
  assign busy      = busy_r;
  assign if_data   = if_data_r;
  assign ls_rdata  = ls_rdata_r;

endmodule
